// File: rtl/march_c_bist_pkg.sv
// March C BIST shared definitions: element and FSM enums, per-element
// operation tables and the failure record carried by the optional log.
package march_pkg;

    typedef enum logic [2:0] {M0, M1, M2, M3, M4, M5} elem_e;

    typedef enum logic [2:0] {IDLE, WR, RD, CMP, NEXT, DONE} state_e;

    // Per-element tables, bit i describes element Mi.
    localparam logic [5:0] ELEM_DOWN = 6'b111000;  // 1 = descending address order
    localparam logic [5:0] HAS_READ  = 6'b111110;
    localparam logic [5:0] READ_EXP  = 6'b010100;  // value expected by the read
    localparam logic [5:0] HAS_WRITE = 6'b011111;
    localparam logic [5:0] WRITE_VAL = 6'b001010;  // value written by the write

    // Record widths cover any supported geometry; users keep the low bits.
    localparam int unsigned REC_ADDR_W = 16;
    localparam int unsigned REC_BIT_W  = 6;

    typedef struct packed {
        logic [REC_ADDR_W-1:0] addr;
        logic [REC_BIT_W-1:0]  bit_pos;
        logic                  exp;
        elem_e                 elem;
    } fail_rec_t;

endpackage

// File: rtl/march_c_bist_fail_log.sv
// Eight-entry failure FIFO (FAIL_LOG_EN builds only). Full pushes are dropped
// and flagged in a sticky overflow bit; a push alongside a pop is accepted.
module march_fail_log
    import march_pkg::*;
#(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned BIT_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              push,
    input  fail_rec_t         push_rec,
    input  logic              pop,
    output logic              log_valid,
    output logic              log_ovf,
    output logic [ADDR_W-1:0] log_addr,
    output logic [BIT_W-1:0]  log_bit,
    output logic              log_exp,
    output logic [2:0]        log_elem
);

    fail_rec_t  fifo_q [8];
    fail_rec_t  head;
    logic [2:0] wr_ptr;
    logic [2:0] rd_ptr;
    logic [3:0] cnt;
    logic       do_pop;
    logic       do_push;
    logic       unused_head;

    assign do_pop      = pop && (cnt != 4'd0);
    assign do_push     = push && ((cnt != 4'd8) || do_pop);
    assign head        = fifo_q[rd_ptr];
    assign log_valid   = (cnt != 4'd0);
    assign log_addr    = head.addr[ADDR_W-1:0];
    assign log_bit     = head.bit_pos[BIT_W-1:0];
    assign log_exp     = head.exp;
    assign log_elem    = head.elem;
    assign unused_head = ^head;

    // Storage array: written on accepted pushes, never reset.
    always_ff @(posedge clk) begin
        if (do_push) fifo_q[wr_ptr] <= push_rec;
    end

    // Pointers, occupancy and sticky overflow; start-of-run clear empties the log.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            log_ovf <= 1'b0;
        end else if (clr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            log_ovf <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 3'd1;
            if (do_pop)  rd_ptr <= rd_ptr + 3'd1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 4'd1;
                2'b01:   cnt <= cnt - 4'd1;
                default: cnt <= cnt;
            endcase
            if (push && !do_push) log_ovf <= 1'b1;
        end
    end

endmodule

// File: rtl/march_c_bist.sv
// March C BIST controller for a single-port synchronous-read SRAM with a
// write mask, bitwise (BIT_MODE=1) or word-wide (BIT_MODE=0).
// Optional failure FIFO enabled by defining FAIL_LOG_EN.
module march_c_bist
    import march_pkg::*;
#(
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned BIT_MODE = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic                      mem_we,
    output logic [DATA_W-1:0]         mem_we_mask,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_din,
    input  logic [DATA_W-1:0]         mem_dout,
    output logic                      fail_valid,
    output logic [ADDR_W-1:0]         fail_addr,
    output logic [$clog2(DATA_W)-1:0] fail_bit,
    output logic                      fail_exp,
    output logic [2:0]                fail_elem,
    output logic [CNT_W-1:0]          fail_count
`ifdef FAIL_LOG_EN
    ,
    input  logic                      log_pop,
    output logic                      log_valid,
    output logic [ADDR_W-1:0]         log_addr,
    output logic [$clog2(DATA_W)-1:0] log_bit,
    output logic                      log_exp,
    output logic [2:0]                log_elem,
    output logic                      log_ovf
`endif
);

    localparam int unsigned BW = $clog2(DATA_W);
    localparam int unsigned PW = $clog2(DATA_W + 1);
    localparam int unsigned SW = ((CNT_W > PW) ? CNT_W : PW) + 1;
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
    localparam logic [BW-1:0]     BIT_LAST  = BW'(DATA_W - 1);
    localparam logic [BW-1:0]     BIT_TOP   = (BIT_MODE != 0) ? BIT_LAST : '0;
    localparam logic [SW-1:0]     CNT_MAX   = (SW'(1) << CNT_W) - SW'(1);

    state_e            state_q, state_n, follow;
    elem_e             elem_q, elem_n, elem_inc;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [BW-1:0]     bit_q, bit_n, low_bit;
    logic              up, bit_end, addr_end, elem_end, op_last, mismatch;
    logic [DATA_W-1:0] mask_c, exp_word, diff;
    logic [PW-1:0]     pop;
    logic [SW-1:0]     sum;
    logic [CNT_W-1:0]  cnt_n;

    assign busy = (state_q != IDLE) && (state_q != DONE);
    assign done = (state_q == DONE);

    // Counter stepping (bit inside addr inside element), mask and read compare.
    always_comb begin
        up       = !ELEM_DOWN[elem_q];
        elem_inc = (elem_q == M5) ? M5 : elem_e'(elem_q + 3'd1);
        bit_end  = (BIT_MODE == 0) || (up ? (bit_q == BIT_LAST) : (bit_q == '0));
        addr_end = up ? (addr_q == ADDR_LAST) : (addr_q == '0);
        elem_end = bit_end && addr_end;
        op_last  = (state_q == WR) || (state_q == CMP);
        elem_n   = elem_q;
        addr_n   = addr_q;
        bit_n    = bit_q;
        if (op_last) begin
            if (!bit_end) begin
                bit_n = up ? bit_q + BW'(1) : bit_q - BW'(1);
            end else if (!addr_end) begin
                addr_n = up ? addr_q + ADDR_W'(1) : addr_q - ADDR_W'(1);
                bit_n  = up ? '0 : BIT_TOP;
            end else begin
                elem_n = elem_inc;
                addr_n = ELEM_DOWN[elem_inc] ? ADDR_LAST : '0;
                bit_n  = ELEM_DOWN[elem_inc] ? BIT_TOP : '0;
            end
        end
        follow = (elem_end && (elem_q == M5)) ? DONE : (HAS_READ[elem_n] ? RD : WR);

        mask_c = '0;
        if (BIT_MODE != 0) mask_c[bit_q] = 1'b1;
        else               mask_c = '1;
        exp_word = {DATA_W{READ_EXP[elem_q]}};
        diff     = (mem_dout ^ exp_word) & mask_c;
        mismatch = (state_q == CMP) && HAS_READ[elem_q] && (diff != '0);
        pop      = PW'($countones(diff));
        low_bit  = '0;
        for (int unsigned i = DATA_W; i > 0; i--) begin
            if (diff[i-1]) low_bit = BW'(i - 1);
        end
        sum   = SW'(fail_count) + SW'(pop);
        cnt_n = (sum > CNT_MAX) ? '1 : sum[CNT_W-1:0];
    end

    // Next state and memory port drive; CMP carries the element's write.
    always_comb begin
        state_n     = state_q;
        mem_we      = 1'b0;
        mem_we_mask = '0;
        mem_addr    = '0;
        mem_din     = '0;
        case (state_q)
            IDLE: if (start) state_n = WR;
            WR: begin
                mem_we      = 1'b1;
                mem_we_mask = mask_c;
                mem_addr    = addr_q;
                mem_din     = WRITE_VAL[elem_q] ? mask_c : '0;
                state_n     = follow;
            end
            RD: begin
                mem_addr = addr_q;
                state_n  = CMP;
            end
            CMP: begin
                mem_addr = addr_q;
                if (HAS_WRITE[elem_q]) begin
                    mem_we      = 1'b1;
                    mem_we_mask = mask_c;
                    mem_din     = WRITE_VAL[elem_q] ? mask_c : '0;
                end
                state_n = follow;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_n;
    end

    // Iteration counters, first-failure capture, saturating count and verdict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            elem_q     <= M0;
            addr_q     <= '0;
            bit_q      <= '0;
            fail_valid <= 1'b0;
            fail_addr  <= '0;
            fail_bit   <= '0;
            fail_exp   <= 1'b0;
            fail_elem  <= '0;
            fail_count <= '0;
            pass       <= 1'b0;
        end else if ((state_q == IDLE) && start) begin
            elem_q     <= M0;
            addr_q     <= '0;
            bit_q      <= '0;
            fail_valid <= 1'b0;
            fail_addr  <= '0;
            fail_bit   <= '0;
            fail_exp   <= 1'b0;
            fail_elem  <= '0;
            fail_count <= '0;
            pass       <= 1'b0;
        end else begin
            elem_q <= elem_n;
            addr_q <= addr_n;
            bit_q  <= bit_n;
            if (mismatch) begin
                fail_count <= cnt_n;
                if (!fail_valid) begin
                    fail_valid <= 1'b1;
                    fail_addr  <= addr_q;
                    fail_bit   <= low_bit;
                    fail_exp   <= READ_EXP[elem_q];
                    fail_elem  <= elem_q;
                end
            end
            if ((state_q == CMP) && (state_n == DONE))
                pass <= !mismatch && (fail_count == '0);
        end
    end

`ifdef FAIL_LOG_EN
    fail_rec_t log_push_rec;

    assign log_push_rec = '{addr: REC_ADDR_W'(addr_q), bit_pos: REC_BIT_W'(low_bit),
                            exp: READ_EXP[elem_q], elem: elem_q};

    march_fail_log #(.ADDR_W(ADDR_W), .BIT_W(BW)) u_fail_log (
        .clk      (clk),
        .rst      (rst),
        .clr      ((state_q == IDLE) && start),
        .push     (mismatch),
        .push_rec (log_push_rec),
        .pop      (log_pop),
        .log_valid(log_valid),
        .log_ovf  (log_ovf),
        .log_addr (log_addr),
        .log_bit  (log_bit),
        .log_exp  (log_exp),
        .log_elem (log_elem)
    );
`endif

endmodule

// File: tb/tb_march_c_bist.sv
// Self-checking bench for march_c_bist: a bitwise 64x8 instance and a word-mode
// 64x8 instance (2-bit fail counter) each drive a behavioural SRAM with faults.
module tb_march_c_bist;

    localparam int N        = 64;
    localparam int DW       = 8;
    localparam int BIT_CYC  = 11 * N * DW;
    localparam int WORD_CYC = 11 * N;
    localparam int CYC_LIM  = 20000;

    typedef struct {
        int cycles;
        bit pass;
        bit fv;
        int addr;
        int fbit;
        bit fexp;
        int elem;
        int cnt;
    } exp_t;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        pass;
        logic        fv;
        logic [5:0]  faddr;
        logic [2:0]  fbit;
        logic        fexp;
        logic [2:0]  felem;
        logic [15:0] fcnt;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    logic b_start, b_busy, b_done, b_pass, b_we, b_fv, b_fexp;
    logic w_start, w_busy, w_done, w_pass, w_we, w_fv, w_fexp;
    logic [7:0]  b_mask, b_din, b_dout, w_mask, w_din, w_dout;
    logic [5:0]  b_addr, b_faddr, w_addr, w_faddr;
    logic [2:0]  b_fbit, b_felem, w_fbit, w_felem;
    logic [15:0] b_fcnt;
    logic [1:0]  w_fcnt;
`ifdef FAIL_LOG_EN
    logic b_lv, b_lexp, b_lovf, w_lv, w_lexp, w_lovf;
    logic [5:0] b_laddr, w_laddr;
    logic [2:0] b_lbit, b_lelem, w_lbit, w_lelem;
`endif

    logic [7:0] mem_b [N];
    logic [7:0] mem_w [N];
    int fault_kind;  // 0 none, 1 SA1 bit, 2 SA0 bit, 3 blocked 0->1 bit, 4 word stuck all-ones
    int f_addr;
    int f_bit;

    exp_t sb_q [$];
    int   n_run  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    march_c_bist #(.ADDR_W(6), .DATA_W(8), .BIT_MODE(1), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done), .pass(b_pass),
        .mem_we(b_we), .mem_we_mask(b_mask), .mem_addr(b_addr), .mem_din(b_din),
        .mem_dout(b_dout), .fail_valid(b_fv), .fail_addr(b_faddr), .fail_bit(b_fbit),
        .fail_exp(b_fexp), .fail_elem(b_felem), .fail_count(b_fcnt)
`ifdef FAIL_LOG_EN
        , .log_pop(1'b0), .log_valid(b_lv), .log_addr(b_laddr), .log_bit(b_lbit),
        .log_exp(b_lexp), .log_elem(b_lelem), .log_ovf(b_lovf)
`endif
    );

    march_c_bist #(.ADDR_W(6), .DATA_W(8), .BIT_MODE(0), .CNT_W(2)) dut_w (
        .clk(clk), .rst(rst), .start(w_start), .busy(w_busy), .done(w_done), .pass(w_pass),
        .mem_we(w_we), .mem_we_mask(w_mask), .mem_addr(w_addr), .mem_din(w_din),
        .mem_dout(w_dout), .fail_valid(w_fv), .fail_addr(w_faddr), .fail_bit(w_fbit),
        .fail_exp(w_fexp), .fail_elem(w_felem), .fail_count(w_fcnt)
`ifdef FAIL_LOG_EN
        , .log_pop(1'b0), .log_valid(w_lv), .log_addr(w_laddr), .log_bit(w_lbit),
        .log_exp(w_lexp), .log_elem(w_lelem), .log_ovf(w_lovf)
`endif
    );

    function automatic logic [7:0] fault_rd(input int a, input logic [7:0] v);
        logic [7:0] r;
        r = v;
        if (a == f_addr) begin
            case (fault_kind)
                1:       r[f_bit] = 1'b1;
                2:       r[f_bit] = 1'b0;
                4:       r = 8'hFF;
                default: r = v;
            endcase
        end
        return r;
    endfunction

    function automatic logic [7:0] fault_wr(input int a, input logic [7:0] old,
                                            input logic [7:0] mask, input logic [7:0] din);
        logic [7:0] r;
        r = (old & ~mask) | (din & mask);
        if (a == f_addr && fault_kind == 3 && !old[f_bit] && r[f_bit]) r[f_bit] = 1'b0;
        return fault_rd(a, r);
    endfunction

    // Behavioural SRAMs: registered read, masked write, fault applied on both paths
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                mem_b[i] <= 8'($urandom);
                mem_w[i] <= 8'($urandom);
            end
        end else begin
            b_dout <= fault_rd(int'(b_addr), mem_b[b_addr]);
            w_dout <= fault_rd(int'(w_addr), mem_w[w_addr]);
            if (b_we) mem_b[b_addr] <= fault_wr(int'(b_addr), mem_b[b_addr], b_mask, b_din);
            if (w_we) mem_w[w_addr] <= fault_wr(int'(w_addr), mem_w[w_addr], w_mask, w_din);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_run++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    function automatic obs_t observe(input bit word);
        obs_t o;
        if (word) o = '{w_busy, w_done, w_pass, w_fv, w_faddr, w_fbit, w_fexp, w_felem, 16'(w_fcnt)};
        else      o = '{b_busy, b_done, b_pass, b_fv, b_faddr, b_fbit, b_fexp, b_felem, b_fcnt};
        return o;
    endfunction

    task automatic run_test(input string name, input bit word, input int kind, input int fa,
                            input int fb, input exp_t e, input bit poke_busy, input bit poke_done);
        int   cyc;
        bit   seen;
        exp_t x;
        obs_t o;
        fault_kind = kind;
        f_addr     = fa;
        f_bit      = fb;
        sb_q.push_back(e);
        @(negedge clk);
        if (word) w_start = 1'b1; else b_start = 1'b1;
        @(negedge clk);
        w_start = 1'b0;
        b_start = 1'b0;
        o = observe(word);
        check_eq({name, "/busy_on_start"}, 32'(o.busy), 1);
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < CYC_LIM) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            o = observe(word);
            if (o.done) seen = 1'b1;
            else if (poke_busy && cyc == 2000) begin
                if (word) w_start = 1'b1; else b_start = 1'b1;
            end else if (poke_busy && cyc == 2001) begin
                w_start = 1'b0;
                b_start = 1'b0;
            end
        end
        x = sb_q.pop_front();
        if (!seen) begin
            check_eq({name, "/done_timeout"}, 0, 1);
        end else begin
            check_eq({name, "/cycles"},     32'(cyc),     32'(x.cycles));
            check_eq({name, "/busy_done"},  32'(o.busy),  0);
            check_eq({name, "/pass"},       32'(o.pass),  32'(x.pass));
            check_eq({name, "/fail_valid"}, 32'(o.fv),    32'(x.fv));
            check_eq({name, "/fail_addr"},  32'(o.faddr), 32'(x.addr));
            check_eq({name, "/fail_bit"},   32'(o.fbit),  32'(x.fbit));
            check_eq({name, "/fail_exp"},   32'(o.fexp),  32'(x.fexp));
            check_eq({name, "/fail_elem"},  32'(o.felem), 32'(x.elem));
            check_eq({name, "/fail_count"}, 32'(o.fcnt),  32'(x.cnt));
            if (poke_done) begin
                if (word) w_start = 1'b1; else b_start = 1'b1;
                @(negedge clk);
                w_start = 1'b0;
                b_start = 1'b0;
                o = observe(word);
                check_eq({name, "/start_at_done_busy"}, 32'(o.busy), 0);
                check_eq({name, "/start_at_done_done"}, 32'(o.done), 0);
                check_eq({name, "/pass_hold"},          32'(o.pass), 32'(x.pass));
            end
        end
    endtask

    initial begin
        int done_cnt;
        int busy_cnt;
        rst        = 1'b1;
        b_start    = 1'b0;
        w_start    = 1'b0;
        fault_kind = 0;
        f_addr     = 0;
        f_bit      = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst/b_busy", 32'(b_busy), 0);
        check_eq("rst/b_done", 32'(b_done), 0);
        check_eq("rst/b_pass", 32'(b_pass), 0);
        check_eq("rst/b_we",   32'(b_we),   0);
        check_eq("rst/b_mask", 32'(b_mask), 0);
        check_eq("rst/b_fcnt", 32'(b_fcnt), 0);
        check_eq("rst/w_busy", 32'(w_busy), 0);
        check_eq("rst/w_fv",   32'(w_fv),   0);
        rst = 1'b0;

        run_test("clean_bit",   0, 0, 0,  0, '{BIT_CYC, 1, 0, 0, 0, 0, 0, 0}, 0, 1);
        run_test("sa1_bit",     0, 1, 10, 2, '{BIT_CYC, 0, 1, 10, 2, 0, 1, 3}, 0, 0);
        run_test("sa0_bit",     0, 2, 60, 3, '{BIT_CYC, 0, 1, 60, 3, 1, 2, 2}, 1, 0);
        run_test("tf_bit",      0, 3, 15, 5, '{BIT_CYC, 0, 1, 15, 5, 1, 2, 2}, 0, 0);
        run_test("clean_word",  1, 0, 0,  0, '{WORD_CYC, 1, 0, 0, 0, 0, 0, 0}, 0, 1);
        run_test("sa1_word",    1, 1, 10, 2, '{WORD_CYC, 0, 1, 10, 2, 0, 1, 3}, 0, 0);
        run_test("sa0_word",    1, 2, 60, 3, '{WORD_CYC, 0, 1, 60, 3, 1, 2, 2}, 0, 0);
        run_test("sat_word",    1, 4, 33, 0, '{WORD_CYC, 0, 1, 33, 0, 0, 1, 3}, 0, 0);

        // Abort a bitwise run with an asynchronous reset part way through M1.
        fault_kind = 1;
        f_addr     = 10;
        f_bit      = 2;
        @(negedge clk);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        repeat (999) begin
            @(posedge clk);
            @(negedge clk);
        end
        check_eq("abort/pre_busy", 32'(b_busy), 1);
        check_eq("abort/pre_fv",   32'(b_fv),   1);
        check_eq("abort/pre_fcnt", 32'(b_fcnt), 1);
        #2 rst = 1'b1;
        #1;
        check_eq("abort/busy",  32'(b_busy),  0);
        check_eq("abort/done",  32'(b_done),  0);
        check_eq("abort/pass",  32'(b_pass),  0);
        check_eq("abort/we",    32'(b_we),    0);
        check_eq("abort/mask",  32'(b_mask),  0);
        check_eq("abort/addr",  32'(b_addr),  0);
        check_eq("abort/din",   32'(b_din),   0);
        check_eq("abort/fv",    32'(b_fv),    0);
        check_eq("abort/faddr", 32'(b_faddr), 0);
        check_eq("abort/fbit",  32'(b_fbit),  0);
        check_eq("abort/felem", 32'(b_felem), 0);
        check_eq("abort/fcnt",  32'(b_fcnt),  0);
        @(negedge clk);
        @(negedge clk);
        rst      = 1'b0;
        done_cnt = 0;
        busy_cnt = 0;
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
            if (b_done) done_cnt++;
            if (b_busy) busy_cnt++;
        end
        check_eq("abort/no_done", 32'(done_cnt), 0);
        check_eq("abort/no_busy", 32'(busy_cnt), 0);

        run_test("restart_bit", 0, 1, 10, 2, '{BIT_CYC, 0, 1, 10, 2, 0, 1, 3}, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
